// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller_if
// Purpose  : Bundles the fetch controller's decode-side, redirect and
//            instruction-memory signals so they travel as one port.
// Ports    : master modport - the fetch controller (drives imem_req,
//            imem_addr, instr_valid, instr, instr_pc, PC).
//            slave modport  - the surrounding core / memory model (drives
//            stall, PCsrc, ImmOp, redirect, redirect_pc, imem_ack,
//            imem_rdata).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_controller_if #(
  parameter int WIDTH = 5
);
  // Decode / branch side
  logic             stall;
  logic             PCsrc;
  logic [31:0]      ImmOp;
  // Flush / trap redirect
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  // Instruction memory handshake
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  // Buffered instruction for decode
  logic             instr_valid;
  logic [31:0]      instr;
  logic [WIDTH-1:0] instr_pc;
  logic [WIDTH-1:0] PC;

  modport master (
    input  stall, PCsrc, ImmOp, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, PC
  );

  modport slave (
    output stall, PCsrc, ImmOp, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, PC
  );
endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Purpose  : Owns the program counter, fetches one instruction at a time from
//            word-addressed instruction memory over a req/ack handshake and
//            buffers it for decode. Applies branch (PCsrc/ImmOp) and
//            flush/trap redirects; a fetch already in flight when a redirect
//            lands is waited out and its data discarded.
// Ports    : clk  - clock, all state changes on posedge
//            rst  - synchronous reset, active low
//            bus  - fetch_controller_if.master (imem handshake, decode
//                   buffer, redirect and branch inputs, PC)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int                 WIDTH    = 5,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  fetch_controller_if.master    bus
);

  localparam logic [WIDTH-1:0] c_PC_INC = WIDTH'(1);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_SQUASH = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_addr;
  logic             r_req;
  logic             r_valid;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_instr_pc;

  // Next sequential fetch address and branch target, both modulo 2^WIDTH.
  logic [WIDTH-1:0] w_seq_pc;
  logic [WIDTH-1:0] w_branch_pc;
  // PC to fetch after decode consumes the buffered instruction.
  logic [WIDTH-1:0] w_consume_pc;

  assign w_seq_pc     = r_addr + c_PC_INC;
  assign w_branch_pc  = r_instr_pc + bus.ImmOp[WIDTH-1:0];
  assign w_consume_pc = bus.PCsrc ? w_branch_pc : r_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_addr     <= '0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          r_addr  <= r_pc;
          r_req   <= 1'b1;
        end

        S_FETCH: begin
          if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
            if (bus.imem_ack) begin
              // Request completed on the old path: drop it and restart.
              r_addr <= bus.redirect_pc;
            end else begin
              // The old request is still outstanding; the address must stay
              // stable until memory acknowledges it.
              r_state <= S_SQUASH;
            end
          end else if (bus.imem_ack) begin
            r_state    <= S_HOLD;
            r_instr    <= bus.imem_rdata;
            r_instr_pc <= r_addr;
            r_pc       <= w_seq_pc;
            r_valid    <= 1'b1;
            r_req      <= 1'b0;
          end
        end

        S_SQUASH: begin
          if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
          end
          if (bus.imem_ack) begin
            // Stale data is discarded; fetch from the newest PC.
            r_state <= S_FETCH;
            r_addr  <= bus.redirect ? bus.redirect_pc : r_pc;
          end
        end

        S_HOLD: begin
          if (bus.redirect) begin
            r_state <= S_FETCH;
            r_pc    <= bus.redirect_pc;
            r_addr  <= bus.redirect_pc;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
          end else if (!bus.stall) begin
            r_state <= S_FETCH;
            r_pc    <= w_consume_pc;
            r_addr  <= w_consume_pc;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.PC          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Purpose  : Directed self-checking bench for fetch_controller. The memory
//            model returns 0xC0DE0000 | address so captured instructions can
//            be recognised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  localparam int c_WIDTH = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_controller_if #(.WIDTH(c_WIDTH)) bus ();

  fetch_controller #(.WIDTH(c_WIDTH), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = 32'hC0DE_0000 | 32'(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // inputs are changed there too, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.PCsrc = 1'b0;
    bus.ImmOp = '0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_ack = 1'b0;

    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_req",   32'(bus.imem_req),    32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_pc",    32'(bus.PC),          32'd0);
    check("rst_addr",  32'(bus.imem_addr),   32'd0);
    check("rst_instr", bus.instr,            32'd0);
    check("rst_ipc",   32'(bus.instr_pc),    32'd0);

    // ---------------- sequential fetch, ack tied high ----------------
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    tick();  // BOOT -> FETCH
    check("boot_req",   32'(bus.imem_req),    32'd1);
    check("boot_addr",  32'(bus.imem_addr),   32'd0);
    check("boot_valid", 32'(bus.instr_valid), 32'd0);
    tick();  // FETCH -> HOLD
    check("f0_valid", 32'(bus.instr_valid), 32'd1);
    check("f0_req",   32'(bus.imem_req),    32'd0);
    check("f0_instr", bus.instr,            32'hC0DE_0000);
    check("f0_ipc",   32'(bus.instr_pc),    32'd0);
    check("f0_pc",    32'(bus.PC),          32'd1);
    for (int i = 1; i < 34; i++) begin
      tick();
      check("seq_addr",  32'(bus.imem_addr),   32'(i % 32));
      check("seq_vlow",  32'(bus.instr_valid), 32'd0);
      tick();
      check("seq_ipc",   32'(bus.instr_pc),    32'(i % 32));
      check("seq_vhigh", 32'(bus.instr_valid), 32'd1);
      check("seq_pc",    32'(bus.PC),          32'((i + 1) % 32));
    end
    // Now in HOLD with instr_pc=1, PC=2.

    // ---------------- branches ----------------
    bus.redirect = 1'b1;
    bus.redirect_pc = 5'd4;
    tick();  // HOLD redirect -> FETCH @4
    bus.redirect = 1'b0;
    check("rd4_addr", 32'(bus.imem_addr), 32'd4);
    tick();  // HOLD ipc=4
    check("rd4_ipc", 32'(bus.instr_pc), 32'd4);
    bus.PCsrc = 1'b1;
    bus.ImmOp = 32'hFFFF_FFFE;
    tick();  // backward branch: 4 - 2
    bus.PCsrc = 1'b0;
    check("brn_addr", 32'(bus.imem_addr), 32'd2);
    check("brn_pc",   32'(bus.PC),        32'd2);
    tick();  // HOLD ipc=2
    bus.redirect = 1'b1;
    bus.redirect_pc = 5'd4;
    tick();
    bus.redirect = 1'b0;
    tick();  // HOLD ipc=4
    check("rd4b_ipc", 32'(bus.instr_pc), 32'd4);
    bus.PCsrc = 1'b1;
    bus.ImmOp = 32'h0000_0023;
    tick();  // upper ImmOp bits ignored: 4 + 3
    bus.PCsrc = 1'b0;
    check("brp_addr", 32'(bus.imem_addr), 32'd7);
    tick();  // HOLD ipc=7, PC=8
    check("h7_instr", bus.instr, 32'hC0DE_0007);

    // ---------------- stall ----------------
    bus.stall = 1'b1;
    bus.PCsrc = 1'b1;
    bus.ImmOp = 32'd5;
    tick();
    bus.PCsrc = 1'b0;
    tick();
    bus.PCsrc = 1'b1;
    tick();
    check("stl_valid", 32'(bus.instr_valid), 32'd1);
    check("stl_req",   32'(bus.imem_req),    32'd0);
    check("stl_ipc",   32'(bus.instr_pc),    32'd7);
    check("stl_pc",    32'(bus.PC),          32'd8);
    check("stl_instr", bus.instr,            32'hC0DE_0007);
    bus.stall = 1'b0;
    bus.PCsrc = 1'b0;
    tick();  // consumed -> FETCH @8
    check("stl_next", 32'(bus.imem_addr), 32'd8);

    // ---------------- redirect with same-cycle ack in FETCH ----------------
    bus.redirect = 1'b1;
    bus.redirect_pc = 5'd5;
    tick();
    check("rda_addr",  32'(bus.imem_addr),   32'd5);
    check("rda_req",   32'(bus.imem_req),    32'd1);
    check("rda_valid", 32'(bus.instr_valid), 32'd0);
    check("rda_pc",    32'(bus.PC),          32'd5);

    // ---------------- squash of delayed fetch ----------------
    bus.imem_ack = 1'b0;
    bus.redirect_pc = 5'd20;
    tick();  // FETCH -> SQUASH
    bus.redirect = 1'b0;
    check("sq_addr1", 32'(bus.imem_addr), 32'd5);
    check("sq_pc",    32'(bus.PC),        32'd20);
    tick();
    tick();
    check("sq_addr3", 32'(bus.imem_addr),   32'd5);
    check("sq_req",   32'(bus.imem_req),    32'd1);
    check("sq_valid", 32'(bus.instr_valid), 32'd0);
    bus.imem_ack = 1'b1;
    tick();  // stale ack -> FETCH @20
    check("sq_naddr", 32'(bus.imem_addr),   32'd20);
    check("sq_nval",  32'(bus.instr_valid), 32'd0);
    check("sq_drop",  bus.instr,            32'hC0DE_0007);
    tick();  // HOLD ipc=20
    check("sq_ipc",   32'(bus.instr_pc), 32'd20);
    check("sq_instr", bus.instr,         32'hC0DE_0014);

    // ---------------- redirect in HOLD beats stall and PCsrc ----------------
    bus.stall = 1'b1;
    bus.PCsrc = 1'b1;
    bus.ImmOp = 32'd3;
    bus.redirect = 1'b1;
    bus.redirect_pc = 5'd9;
    tick();
    bus.stall = 1'b0;
    bus.PCsrc = 1'b0;
    bus.redirect = 1'b0;
    check("hrd_addr",  32'(bus.imem_addr),   32'd9);
    check("hrd_pc",    32'(bus.PC),          32'd9);
    check("hrd_valid", 32'(bus.instr_valid), 32'd0);
    tick();  // HOLD ipc=9
    check("hrd_ipc", 32'(bus.instr_pc), 32'd9);

    // ---------------- reset in SQUASH with pending ack ----------------
    bus.imem_ack = 1'b0;
    tick();  // FETCH @10
    bus.redirect = 1'b1;
    bus.redirect_pc = 5'd15;
    tick();  // SQUASH
    bus.redirect = 1'b0;
    check("rsq_addr", 32'(bus.imem_addr), 32'd10);
    rst = 1'b0;
    bus.imem_ack = 1'b1;
    tick();  // reset wins over the ack
    check("rsq_pc",    32'(bus.PC),          32'd0);
    check("rsq_req",   32'(bus.imem_req),    32'd0);
    check("rsq_valid", 32'(bus.instr_valid), 32'd0);
    check("rsq_addr0", 32'(bus.imem_addr),   32'd0);
    rst = 1'b1;
    tick();  // BOOT ignores the late ack
    check("rsq_boot_req",   32'(bus.imem_req),    32'd1);
    check("rsq_boot_valid", 32'(bus.instr_valid), 32'd0);
    check("rsq_boot_addr",  32'(bus.imem_addr),   32'd0);
    tick();
    check("rsq_ipc",   32'(bus.instr_pc), 32'd0);
    check("rsq_instr", bus.instr,         32'hC0DE_0000);
    check("rsq_pc1",   32'(bus.PC),       32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
